// File: rtl/hub75_fb_arbiter.sv
// hub75_fb_arbiter: shares one single-port frame RAM between display reads (front bank) and host writes (back bank),
// with starvation-bounded write priority and frame-boundary bank swapping.
module hub75_fb_arbiter #(
  parameter int hpixel_p = 64,
  parameter int vpixel_p = 64,
  parameter int bpp_p = 8,
  parameter int starve_limit_p = 8,
  localparam int addr_width_p = $clog2(hpixel_p*vpixel_p),
  localparam int data_width_p = 3*bpp_p
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_rd_valid,
  output logic                    o_rd_ready,
  input  logic [addr_width_p-1:0] i_rd_addr,
  output logic                    o_rd_valid,
  output logic [data_width_p-1:0] o_rd_data,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic [addr_width_p-1:0] i_wr_addr,
  input  logic [data_width_p-1:0] i_wr_data,
  input  logic                    i_swap_req,
  input  logic                    i_frame_done,
  output logic                    o_swap_ack,
  output logic                    o_swap_pending,
  output logic                    o_front_bank,
  output logic                    o_mem_en,
  output logic                    o_mem_we,
  output logic [addr_width_p:0]   o_mem_addr,
  output logic [data_width_p-1:0] o_mem_wdata,
  input  logic [data_width_p-1:0] i_mem_rdata
);
  localparam int cnt_w = $clog2(starve_limit_p+1);
  localparam logic [cnt_w-1:0] lim = cnt_w'(starve_limit_p);
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [cnt_w-1:0] starve_q, starve_d;
  logic [0:0] state_q, state_d;
  logic front_q, front_d;
  logic ack_q, p1_q, rd_valid_q;
  logic [data_width_p-1:0] rd_data_q;
  logic force_wr, wr_block, swap_exec;

  always_comb begin
    force_wr = starve_q == lim;
    wr_block = state_q == PEND;
    o_wr_ready = i_wr_valid & !wr_block & (!i_rd_valid | force_wr);
    o_rd_ready = i_rd_valid & !(force_wr & i_wr_valid & !wr_block);
    o_mem_en = o_rd_ready | o_wr_ready;
    o_mem_we = o_wr_ready;
    o_mem_addr = o_wr_ready ? {~front_q, i_wr_addr} : o_rd_ready ? {front_q, i_rd_addr} : '0;
    o_mem_wdata = o_wr_ready ? i_wr_data : '0;
    starve_d = (!i_wr_valid | wr_block | o_wr_ready) ? '0 : force_wr ? starve_q : starve_q + 1'b1;
    // a request arriving together with frame_done swaps at once rather than waiting a frame
    swap_exec = i_frame_done & (state_q == PEND | i_swap_req);
    state_d = swap_exec ? RUN : i_swap_req ? PEND : state_q;
    front_d = front_q ^ swap_exec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      state_q <= RUN;
      front_q <= 1'b0;
      ack_q <= 1'b0;
      p1_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      starve_q <= starve_d;
      state_q <= state_d;
      front_q <= front_d;
      ack_q <= swap_exec;
      p1_q <= o_rd_ready;
      rd_valid_q <= p1_q;
      if (p1_q) rd_data_q <= i_mem_rdata;
    end
  end

  assign o_rd_valid = rd_valid_q;
  assign o_rd_data = rd_data_q;
  assign o_swap_ack = ack_q;
  assign o_swap_pending = state_q == PEND;
  assign o_front_bank = front_q;
endmodule

// File: doc/hub75_fb_arbiter.md
# hub75_fb_arbiter

Arbitration and bank-swap controller for the double-buffered HUB75 frame memory. Shares one single-port, one-cycle-latency RAM between the display read path and the host write path, which run in the same clock domain. The display read path is the row shifter sequenced by the panel controller. Display reads always target the front bank and host writes always target the back bank. Banks swap only at a frame boundary, so the panel never shows a torn frame.

## Interface
- `hpixel_p`, default 64: display width in pixels.
- `vpixel_p`, default 64: display height in pixels.
- `bpp_p`, default 8: bits per colour channel; pixel word is `3*bpp_p` (R,G,B; R in MSBs).
- `starve_limit_p`, default 8: maximum consecutive cycles a valid, unblocked host write may lose to reads.
- Derived: `addr_width_p = $clog2(hpixel_p*vpixel_p)`; `data_width_p = 3*bpp_p`.

Ports:
- `clk`, input, 1: single clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `i_rd_valid`, input, 1: display read request.
- `o_rd_ready`, output, 1: read accepted this cycle.
- `i_rd_addr`, input, `addr_width_p`: pixel address within the front bank.
- `o_rd_valid`, output, 1: read data valid (one-cycle pulse per accepted read).
- `o_rd_data`, output, `data_width_p`: read data.
- `i_wr_valid`, input, 1: host write request.
- `o_wr_ready`, output, 1: write accepted this cycle.
- `i_wr_addr`, input, `addr_width_p`: pixel address within the back bank.
- `i_wr_data`, input, `data_width_p`: write data.
- `i_swap_req`, input, 1: pulse; host finished the back frame.
- `i_frame_done`, input, 1: pulse from the panel controller after the last row/bit plane of a frame.
- `o_swap_ack`, output, 1: one-cycle pulse after a swap has executed.
- `o_swap_pending`, output, 1: a swap has been requested but not yet executed.
- `o_front_bank`, output, 1: bank currently displayed.
- `o_mem_en`, output, 1: RAM access enable.
- `o_mem_we`, output, 1: RAM write enable.
- `o_mem_addr`, output, `addr_width_p+1`: RAM address, `{bank, pixel_addr}`.
- `o_mem_wdata`, output, `data_width_p`: RAM write data.
- `i_mem_rdata`, input, `data_width_p`: RAM read data, valid the cycle after `o_mem_en & !o_mem_we`.

## Operation
- **Grant rule.** Each cycle, at most one of read or write is granted.
  - `force_wr = (starve_cnt == starve_limit_p)`.
  - `wr_block = o_swap_pending`.
  - `o_wr_ready = i_wr_valid & !wr_block & (!i_rd_valid | force_wr)`.
  - `o_rd_ready = i_rd_valid & !(force_wr & i_wr_valid & !wr_block)`.
- **Memory port.** Combinational from the grant.
  - Read grant: `o_mem_en=1`, `o_mem_we=0`, `o_mem_addr={o_front_bank, i_rd_addr}`.
  - Write grant: `o_mem_en=1`, `o_mem_we=1`, `o_mem_addr={~o_front_bank, i_wr_addr}`, `o_mem_wdata=i_wr_data`.
  - No grant: all memory outputs 0.
- **Starvation counter** (`starve_cnt`, width `$clog2(starve_limit_p+1)`):
  - Increments when `i_wr_valid & !wr_block & !o_wr_ready`.
  - Clears on a write grant, or when `!i_wr_valid | wr_block`.
  - Saturates at `starve_limit_p`.
- **Read pipeline.** Two stages.
  - Stage 1 flag: set on a read grant.
  - Stage 2 registers `i_mem_rdata` into `o_rd_data` and pulses `o_rd_valid`.
  - The bank is fixed at grant time. A swap does not redirect reads already in flight.
- **Swap FSM**, states RUN and PEND:
  - RUN → PEND on `i_swap_req`.
  - PEND → RUN on `i_frame_done`: toggle `o_front_bank`, pulse `o_swap_ack` the next cycle.
  - `i_swap_req` and `i_frame_done` in the same cycle in RUN: swap executes that cycle, same as PEND→RUN.
  - `i_swap_req` while in PEND: ignored.
  - `i_frame_done` in RUN: no effect.
  - `o_swap_pending = (state == PEND)`.

## Timing
- **Reset values.** Asserting `rst` forces all of the following; any in-flight read is discarded and no `o_rd_valid` is produced for it.
  - `o_rd_valid=0`, `o_rd_data=0`, `o_swap_ack=0`, `o_front_bank=0`.
  - FSM=RUN, `starve_cnt=0`, pipeline flag 0.
  - Combinational outputs follow the inputs with the reset state.
- **Read latency.** Read accepted at cycle t: `o_mem_en` is high at t, `i_mem_rdata` is sampled at t+1, `o_rd_valid` and `o_rd_data` appear at t+2.
- **Read throughput.** Back-to-back reads give one read per cycle.
- **Write timing.** A write is committed in the same cycle as `o_wr_ready`; there is no write response.
- **Swap visibility.** Reads granted from cycle t+1 onward use the new front bank, where t is the cycle `i_frame_done` executes the swap. `o_swap_ack` is high at t+1 only. Writes are re-enabled at t+1 and target the old front bank.
- **Worst case.** A continuously valid, unblocked write is granted within `starve_limit_p+1` cycles, even under constant reads.

## Test plan
- **Reads only.** Reset, preload bank 0 address 5 = 0x123456, `i_rd_valid` high at cycle 10. Required: `o_mem_addr=0x005` at cycle 10, `o_rd_valid` with data 0x123456 at cycle 12.
- **Write alone.** Write valid with no read, addr 3, data 0xABCDEF. Required: `o_wr_ready=1` the same cycle, `o_mem_we=1`, `o_mem_addr={1, 3}`.
- **Starvation.** `starve_limit_p=8`, read and write both valid continuously. Required: 8 read grants, then 1 write grant, repeating; no cycle grants both.
- **Swap sequence.** Pulse `i_swap_req`, then pulse `i_frame_done` 20 cycles later. Required: `o_wr_ready=0` throughout the pending window; `o_front_bank` changes 0→1 after the `i_frame_done` cycle; `o_swap_ack` high exactly one cycle; the next read uses bank 1.
- **Simultaneous events.** `i_swap_req` and `i_frame_done` in the same cycle, with a read granted the cycle before. Required: swap executes immediately; the in-flight read returns bank 0 data.
- **Reset mid-operation.** Assert `rst` with a read in stage 1 and a swap pending. Required: no `o_rd_valid`, `o_front_bank=0`, `o_swap_pending=0`.
